// File: rtl/byte_stream_wide_adder.sv
// Streaming multi-beat adder/subtractor: two operand streams, LSB beat first,
// carry rippling across lanes and beats, one registered result beat per input beat.
module byte_stream_wide_adder #(
   parameter int DATA_WIDTH    = 8,
   parameter int LANES         = 1,
   parameter int STREAM_LENGTH = 16
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        mode_sub,
   input  logic [LANES*DATA_WIDTH-1:0] a_data,
   input  logic                        a_valid,
   output logic                        a_ready,
   input  logic [LANES*DATA_WIDTH-1:0] b_data,
   input  logic                        b_valid,
   output logic                        b_ready,
   output logic [LANES*DATA_WIDTH-1:0] sum_data,
   output logic                        sum_last,
   output logic                        sum_carry,
   output logic                        sum_ovf,
   output logic                        sum_valid,
   input  logic                        sum_ready
);

   localparam int W  = LANES * DATA_WIDTH;
   localparam int CW = (STREAM_LENGTH > 1) ? $clog2(STREAM_LENGTH) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(STREAM_LENGTH - 1);
   localparam bit SINGLE_BEAT = (STREAM_LENGTH == 1);

   typedef enum logic [0:0] {
      ST_FIRST = 1'b0,
      ST_BODY  = 1'b1
   } state_t;

   state_t          state_r;
   state_t          state_nxt_s;
   logic [CW-1:0]   beat_cnt_r;
   logic [CW-1:0]   beat_cnt_nxt_s;
   logic            carry_r;
   logic            mode_r;

   logic            slot_free_s;
   logic            xfer_s;
   logic            mode_eff_s;
   logic            cin_s;
   logic            is_last_s;
   logic [W-1:0]    b_eff_s;
   logic [W-1:0]    sum_s;
   logic [LANES:0]  lane_c_s;
   logic            cout_s;
   logic            msb_cin_s;

   // A new beat may enter whenever the output register is empty or being drained.
   assign slot_free_s = !sum_valid | sum_ready;
   assign a_ready     = slot_free_s & b_valid;
   assign b_ready     = slot_free_s & a_valid;
   assign xfer_s      = a_valid & b_valid & slot_free_s;

   // First beat takes mode and carry-in from mode_sub; later beats use the latched copies.
   always_comb begin
      mode_eff_s = mode_r;
      cin_s      = carry_r;
      if (state_r == ST_FIRST) begin
         mode_eff_s = mode_sub;
         cin_s      = mode_sub;
      end else begin
         mode_eff_s = mode_r;
         cin_s      = carry_r;
      end
   end

   assign b_eff_s     = mode_eff_s ? ~b_data : b_data;
   assign lane_c_s[0] = cin_s;

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [DATA_WIDTH:0] lane_sum_s;
      assign lane_sum_s = {1'b0, a_data[l*DATA_WIDTH +: DATA_WIDTH]}
                        + {1'b0, b_eff_s[l*DATA_WIDTH +: DATA_WIDTH]}
                        + {{DATA_WIDTH{1'b0}}, lane_c_s[l]};
      assign sum_s[l*DATA_WIDTH +: DATA_WIDTH] = lane_sum_s[DATA_WIDTH-1:0];
      assign lane_c_s[l+1] = lane_sum_s[DATA_WIDTH];
   end

   assign cout_s = lane_c_s[LANES];
   // Carry into the MSB recovered from the MSB sum bit itself.
   assign msb_cin_s = a_data[W-1] ^ b_eff_s[W-1] ^ sum_s[W-1];

   // Marks the beat that closes the packet.
   always_comb begin
      is_last_s = 1'b0;
      if (state_r == ST_FIRST) begin
         is_last_s = SINGLE_BEAT;
      end else begin
         is_last_s = (beat_cnt_r == LAST_CNT);
      end
   end

   // Packet position FSM: next state and beat counter.
   always_comb begin
      state_nxt_s    = state_r;
      beat_cnt_nxt_s = beat_cnt_r;
      case (state_r)
         ST_FIRST: begin
            if (xfer_s) begin
               if (SINGLE_BEAT) begin
                  state_nxt_s    = ST_FIRST;
                  beat_cnt_nxt_s = {CW{1'b0}};
               end else begin
                  state_nxt_s    = ST_BODY;
                  beat_cnt_nxt_s = CW'(1);
               end
            end else begin
               state_nxt_s    = ST_FIRST;
               beat_cnt_nxt_s = beat_cnt_r;
            end
         end
         ST_BODY: begin
            if (xfer_s) begin
               if (is_last_s) begin
                  state_nxt_s    = ST_FIRST;
                  beat_cnt_nxt_s = {CW{1'b0}};
               end else begin
                  state_nxt_s    = ST_BODY;
                  beat_cnt_nxt_s = beat_cnt_r + CW'(1);
               end
            end else begin
               state_nxt_s    = ST_BODY;
               beat_cnt_nxt_s = beat_cnt_r;
            end
         end
         default: begin
            state_nxt_s    = ST_FIRST;
            beat_cnt_nxt_s = {CW{1'b0}};
         end
      endcase
   end

   // State, counter and inter-beat carry/mode registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r    <= ST_FIRST;
         beat_cnt_r <= {CW{1'b0}};
         carry_r    <= 1'b0;
         mode_r     <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         beat_cnt_r <= beat_cnt_nxt_s;
         if (xfer_s) begin
            carry_r <= cout_s;
            if (state_r == ST_FIRST) begin
               mode_r <= mode_sub;
            end
         end
      end
   end

   // Result register: load on transfer, drain when accepted, hold under backpressure.
   always_ff @(posedge clock) begin
      if (reset) begin
         sum_data  <= {W{1'b0}};
         sum_last  <= 1'b0;
         sum_carry <= 1'b0;
         sum_ovf   <= 1'b0;
         sum_valid <= 1'b0;
      end else if (xfer_s) begin
         sum_data  <= sum_s;
         sum_last  <= is_last_s;
         sum_carry <= is_last_s & cout_s;
         sum_ovf   <= is_last_s & (msb_cin_s ^ cout_s);
         sum_valid <= 1'b1;
      end else if (sum_ready) begin
         sum_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_byte_stream_wide_adder.sv
// Directed, table-driven bench for byte_stream_wide_adder (8-bit lanes, 1 lane, 4 beats).
module tb_byte_stream_wide_adder;

   localparam int DW = 8;
   localparam int LN = 1;
   localparam int SL = 4;
   localparam int W  = DW * LN;

   logic         clock = 1'b0;
   logic         reset;
   logic         mode_sub;
   logic [W-1:0] a_data;
   logic         a_valid;
   logic         a_ready;
   logic [W-1:0] b_data;
   logic         b_valid;
   logic         b_ready;
   logic [W-1:0] sum_data;
   logic         sum_last;
   logic         sum_carry;
   logic         sum_ovf;
   logic         sum_valid;
   logic         sum_ready;

   int passed = 0;
   int total  = 0;

   always #5 clock = ~clock;

   byte_stream_wide_adder #(
      .DATA_WIDTH   (DW),
      .LANES        (LN),
      .STREAM_LENGTH(SL)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .mode_sub (mode_sub),
      .a_data   (a_data),
      .a_valid  (a_valid),
      .a_ready  (a_ready),
      .b_data   (b_data),
      .b_valid  (b_valid),
      .b_ready  (b_ready),
      .sum_data (sum_data),
      .sum_last (sum_last),
      .sum_carry(sum_carry),
      .sum_ovf  (sum_ovf),
      .sum_valid(sum_valid),
      .sum_ready(sum_ready)
   );

   typedef struct {
      logic         mode;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] sum;
      logic         last;
      logic         carry;
      logic         ovf;
   } vec_t;

   vec_t vecs[16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) begin
         passed++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic [W-1:0] s, input logic l,
                            input logic c, input logic o);
      check({tag, " valid"}, 32'(sum_valid), 32'd1);
      check({tag, " data"},  32'(sum_data),  32'(s));
      check({tag, " last"},  32'(sum_last),  32'(l));
      check({tag, " carry"}, 32'(sum_carry), 32'(c));
      check({tag, " ovf"},   32'(sum_ovf),   32'(o));
   endtask

   // Present one beat with both valids, clock it in, sample just after the edge.
   task automatic beat(input logic m, input logic [W-1:0] a, input logic [W-1:0] b);
      mode_sub = m;
      a_data   = a;
      b_data   = b;
      a_valid  = 1'b1;
      b_valid  = 1'b1;
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      a_valid = 1'b0;
      b_valid = 1'b0;
   endtask

   task automatic set_vec(input int i, input logic m, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] s, input logic l, input logic c, input logic o);
      vecs[i].mode  = m;
      vecs[i].a     = a;
      vecs[i].b     = b;
      vecs[i].sum   = s;
      vecs[i].last  = l;
      vecs[i].carry = c;
      vecs[i].ovf   = o;
   endtask

   initial begin
      // FF + 01 over 4 beats
      set_vec(0,  1'b0, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0);
      set_vec(1,  1'b0, 8'h00, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0);
      set_vec(2,  1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      set_vec(3,  1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
      // FFFFFFFF + 1: full carry out, no signed overflow
      set_vec(4,  1'b0, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0);
      set_vec(5,  1'b0, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      set_vec(6,  1'b0, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      set_vec(7,  1'b0, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
      // 7FFFFFFF + 1: signed overflow
      set_vec(8,  1'b0, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0);
      set_vec(9,  1'b0, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      set_vec(10, 1'b0, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      set_vec(11, 1'b0, 8'h7F, 8'h00, 8'h80, 1'b1, 1'b0, 1'b1);
      // 0 - 1 with mode_sub dropped mid-packet (must be ignored)
      set_vec(12, 1'b1, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0);
      set_vec(13, 1'b1, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
      set_vec(14, 1'b0, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
      set_vec(15, 1'b0, 8'h00, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0);

      reset     = 1'b1;
      mode_sub  = 1'b0;
      a_data    = 8'h00;
      b_data    = 8'h00;
      a_valid   = 1'b0;
      b_valid   = 1'b0;
      sum_ready = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      check("rst valid", 32'(sum_valid), 32'd0);
      check("rst data",  32'(sum_data),  32'd0);
      check("rst last",  32'(sum_last),  32'd0);
      check("rst carry", 32'(sum_carry), 32'd0);
      check("rst ovf",   32'(sum_ovf),   32'd0);
      reset = 1'b0;

      for (int i = 0; i < 16; i++) begin
         beat(vecs[i].mode, vecs[i].a, vecs[i].b);
         check_out($sformatf("v%0d", i), vecs[i].sum, vecs[i].last, vecs[i].carry, vecs[i].ovf);
      end

      idle();
      @(posedge clock);
      #1;
      check("drain valid", 32'(sum_valid), 32'd0);

      // Backpressure: hold for 3 cycles after beat 1, nothing consumed
      beat(1'b0, 8'hFF, 8'h01);
      check_out("bp b1", 8'h00, 1'b0, 1'b0, 1'b0);
      sum_ready = 1'b0;
      a_data    = 8'h00;
      b_data    = 8'h00;
      #1;
      check("bp a_ready", 32'(a_ready), 32'd0);
      check("bp b_ready", 32'(b_ready), 32'd0);
      for (int k = 0; k < 3; k++) begin
         @(posedge clock);
         #1;
         check($sformatf("bp hold%0d data", k), 32'(sum_data), 32'h00);
         check($sformatf("bp hold%0d valid", k), 32'(sum_valid), 32'd1);
      end
      sum_ready = 1'b1;
      #1;
      check("bp resume a_ready", 32'(a_ready), 32'd1);
      @(posedge clock);
      #1;
      check_out("bp b2", 8'h01, 1'b0, 1'b0, 1'b0);
      beat(1'b0, 8'h00, 8'h00);
      check_out("bp b3", 8'h00, 1'b0, 1'b0, 1'b0);
      beat(1'b0, 8'h00, 8'h00);
      check_out("bp b4", 8'h00, 1'b1, 1'b0, 1'b0);

      // Lone valid never transfers
      a_valid = 1'b1;
      b_valid = 1'b0;
      a_data  = 8'h55;
      #1;
      check("lone a_ready", 32'(a_ready), 32'd0);
      @(posedge clock);
      #1;
      check("lone valid", 32'(sum_valid), 32'd0);

      // Reset after beat 2 of a carry-propagating packet
      beat(1'b0, 8'hFF, 8'h01);
      check_out("rp b1", 8'h00, 1'b0, 1'b0, 1'b0);
      beat(1'b0, 8'hFF, 8'h00);
      check_out("rp b2", 8'h00, 1'b0, 1'b0, 1'b0);
      reset = 1'b1;
      @(posedge clock);
      #1;
      check("rp valid after reset", 32'(sum_valid), 32'd0);
      reset = 1'b0;
      beat(1'b0, 8'hFF, 8'h00);
      check_out("np b1", 8'hFF, 1'b0, 1'b0, 1'b0);
      beat(1'b0, 8'h00, 8'h00);
      check_out("np b2", 8'h00, 1'b0, 1'b0, 1'b0);
      beat(1'b0, 8'h00, 8'h00);
      check_out("np b3", 8'h00, 1'b0, 1'b0, 1'b0);
      beat(1'b0, 8'h00, 8'h00);
      check_out("np b4", 8'h00, 1'b1, 1'b0, 1'b0);
      idle();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
